// File: rtl/axi_intr_ctrl_pkg.sv
// Shared register offsets, response code, irq mode and byte-strobe helper
// for the multi-source AXI4-Lite interrupt controller.
package axi_intr_ctrl_pkg;

  // Word indices taken from address bits [4:2].
  localparam logic [2:0] ADDR_GIE  = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_ISR  = 3'd2;
  localparam logic [2:0] ADDR_IAR  = 3'd3;
  localparam logic [2:0] ADDR_IPR  = 3'd4;
  localparam logic [2:0] ADDR_SENS = 3'd5;
  localparam logic [2:0] ADDR_POL  = 3'd6;
  localparam logic [2:0] ADDR_ISET = 3'd7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IRQ_PULSE = 1'b0,
    IRQ_LEVEL = 1'b1
  } irq_mode_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/intr_src_detect.sv
// One interrupt source: 2-flop synchroniser, polarity, edge/level event.
// Event is valid 2 edges after the input is first sampled; no backpressure.
module intr_src_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_intr,
  input  logic i_pol,
  input  logic i_sens,
  output logic o_evt
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic w_s;
  logic w_s_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_intr;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Polarity is applied to both taps, so flipping POL never fakes an edge.
  assign w_s   = r_sync ^ ~i_pol;
  assign w_s_d = r_sync_d ^ ~i_pol;
  assign o_evt = i_sens ? (w_s & ~w_s_d) : w_s;

endmodule

// File: rtl/axi_intr_ctrl_multi.sv
// AXI4-Lite interrupt controller aggregating C_NUM_OF_INTR sources onto one irq.
// irq follows a source edge by 4 clocks; one outstanding write and read, held by BREADY/RREADY.
module axi_intr_ctrl_multi
  import axi_intr_ctrl_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH  = 32,
  parameter int          C_S_AXI_ADDR_WIDTH  = 5,
  parameter int          C_NUM_OF_INTR       = 4,
  parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFF_FFFF,
  parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFF_FFFF,
  parameter int          C_IRQ_SENSITIVITY   = 1,
  parameter int          C_IRQ_ACTIVE_STATE  = 1,
  parameter int          C_IRQ_PULSE_CYCLES  = 4
) (
  input  logic                            S_AXI_INTR_ACLK,
  input  logic                            S_AXI_INTR_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_AWADDR,
  input  logic [2:0]                      S_AXI_INTR_AWPROT,
  input  logic                            S_AXI_INTR_AWVALID,
  output logic                            S_AXI_INTR_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_INTR_WSTRB,
  input  logic                            S_AXI_INTR_WVALID,
  output logic                            S_AXI_INTR_WREADY,
  output logic [1:0]                      S_AXI_INTR_BRESP,
  output logic                            S_AXI_INTR_BVALID,
  input  logic                            S_AXI_INTR_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_ARADDR,
  input  logic [2:0]                      S_AXI_INTR_ARPROT,
  input  logic                            S_AXI_INTR_ARVALID,
  output logic                            S_AXI_INTR_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_RDATA,
  output logic [1:0]                      S_AXI_INTR_RRESP,
  output logic                            S_AXI_INTR_RVALID,
  input  logic                            S_AXI_INTR_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_in,
  output logic                            irq
);

  localparam logic [31:0] MASK = (C_NUM_OF_INTR >= 32) ? 32'hFFFF_FFFF :
                                 ((32'd1 << C_NUM_OF_INTR) - 32'd1);
  localparam irq_mode_e MODE   = (C_IRQ_SENSITIVITY != 0) ? IRQ_LEVEL : IRQ_PULSE;
  localparam logic      IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);
  localparam int        CW     = $clog2(C_IRQ_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(C_IRQ_PULSE_CYCLES);

  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        r_gie;
  logic [31:0] r_ier;
  logic [31:0] r_isr;
  logic [31:0] r_sens;
  logic [31:0] r_pol;

  logic          r_cond_d;
  logic [CW-1:0] r_cnt;
  logic          r_irq;

  logic                     w_wr_hs;
  logic                     w_rd_hs;
  logic [2:0]               w_wr_idx;
  logic [2:0]               w_rd_idx;
  logic [31:0]              w_bmask;
  logic [31:0]              w_wbits;
  logic [31:0]              w_iar_clr;
  logic [31:0]              w_iset;
  logic [C_NUM_OF_INTR-1:0] w_evt;
  logic [31:0]              w_evt_all;
  logic [31:0]              w_set_edge;
  logic [31:0]              w_set_lvl;
  logic [31:0]              w_ipr;
  logic [31:0]              w_rd_dat;
  logic                     w_cond;
  logic [CW-1:0]            w_cnt_nxt;
  logic                     w_unused_ok;

  assign w_wr_hs  = r_awready & S_AXI_INTR_AWVALID & r_wready & S_AXI_INTR_WVALID;
  assign w_rd_hs  = r_arready & S_AXI_INTR_ARVALID;
  assign w_wr_idx = S_AXI_INTR_AWADDR[4:2];
  assign w_rd_idx = S_AXI_INTR_ARADDR[4:2];
  assign w_bmask  = strb_mask(S_AXI_INTR_WSTRB);
  assign w_wbits  = S_AXI_INTR_WDATA & w_bmask & MASK;

  assign w_iar_clr = (w_wr_hs && w_wr_idx == ADDR_IAR)  ? w_wbits : 32'h0;
  assign w_iset    = (w_wr_hs && w_wr_idx == ADDR_ISET) ? w_wbits : 32'h0;

  assign w_unused_ok = &{1'b0, S_AXI_INTR_AWPROT, S_AXI_INTR_ARPROT,
                         S_AXI_INTR_AWADDR, S_AXI_INTR_ARADDR};

  for (genvar gi = 0; gi < C_NUM_OF_INTR; gi++) begin : g_src
    intr_src_detect u_det (
      .i_clk   (S_AXI_INTR_ACLK),
      .i_rst_n (S_AXI_INTR_ARESETN),
      .i_intr  (intr_in[gi]),
      .i_pol   (r_pol[gi]),
      .i_sens  (r_sens[gi]),
      .o_evt   (w_evt[gi])
    );
  end

  always_comb begin
    w_evt_all = 32'h0;
    w_evt_all[C_NUM_OF_INTR-1:0] = w_evt;
  end

  assign w_set_edge = w_evt_all & r_sens;
  assign w_set_lvl  = w_evt_all & ~r_sens;
  assign w_ipr      = r_isr & r_ier;

  // Write channel: both READYs pulse once per accepted write.
  always_ff @(posedge S_AXI_INTR_ACLK or negedge S_AXI_INTR_ARESETN) begin
    if (!S_AXI_INTR_ARESETN) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (!r_awready && S_AXI_INTR_AWVALID && S_AXI_INTR_WVALID && !r_bvalid) begin
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
      end else begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
      end
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
      end else if (S_AXI_INTR_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_INTR_ACLK or negedge S_AXI_INTR_ARESETN) begin
    if (!S_AXI_INTR_ARESETN) begin
      r_gie  <= 1'b0;
      r_ier  <= 32'h0;
      r_sens <= C_INTR_SENSITIVITY & MASK;
      r_pol  <= C_INTR_ACTIVE_STATE & MASK;
    end else if (w_wr_hs) begin
      case (w_wr_idx)
        ADDR_GIE:  if (S_AXI_INTR_WSTRB[0]) r_gie <= S_AXI_INTR_WDATA[0];
        ADDR_IER:  r_ier  <= (r_ier  & ~w_bmask) | w_wbits;
        ADDR_SENS: r_sens <= (r_sens & ~w_bmask) | w_wbits;
        ADDR_POL:  r_pol  <= (r_pol  & ~w_bmask) | w_wbits;
        default: ;
      endcase
    end
  end

  // Edge events and ISET beat a same-edge ack; a held level source is masked
  // for that one edge so the ack is visible, then re-asserts on the next.
  always_ff @(posedge S_AXI_INTR_ACLK or negedge S_AXI_INTR_ARESETN) begin
    if (!S_AXI_INTR_ARESETN) begin
      r_isr <= 32'h0;
    end else begin
      r_isr <= ((r_isr & ~w_iar_clr) | w_set_edge | w_iset |
                (w_set_lvl & ~w_iar_clr)) & MASK;
    end
  end

  always_comb begin
    w_rd_dat = 32'h0;
    case (w_rd_idx)
      ADDR_GIE:  w_rd_dat = {31'h0, r_gie};
      ADDR_IER:  w_rd_dat = r_ier;
      ADDR_ISR:  w_rd_dat = r_isr;
      ADDR_IPR:  w_rd_dat = w_ipr;
      ADDR_SENS: w_rd_dat = r_sens;
      ADDR_POL:  w_rd_dat = r_pol;
      default:   w_rd_dat = 32'h0;
    endcase
  end

  always_ff @(posedge S_AXI_INTR_ACLK or negedge S_AXI_INTR_ARESETN) begin
    if (!S_AXI_INTR_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_arready <= !r_arready && S_AXI_INTR_ARVALID && !r_rvalid;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_dat;
      end else if (S_AXI_INTR_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign w_cond = r_gie & (|w_ipr);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_cond && !r_cond_d) begin
      w_cnt_nxt = PULSE_LD;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge S_AXI_INTR_ACLK or negedge S_AXI_INTR_ARESETN) begin
    if (!S_AXI_INTR_ARESETN) begin
      r_cond_d <= 1'b0;
      r_cnt    <= '0;
      r_irq    <= ~IRQ_ON;
    end else begin
      r_cond_d <= w_cond;
      r_cnt    <= w_cnt_nxt;
      if (MODE == IRQ_LEVEL) begin
        r_irq <= w_cond ? IRQ_ON : ~IRQ_ON;
      end else begin
        r_irq <= (w_cnt_nxt != '0) ? IRQ_ON : ~IRQ_ON;
      end
    end
  end

  assign S_AXI_INTR_AWREADY = r_awready;
  assign S_AXI_INTR_WREADY  = r_wready;
  assign S_AXI_INTR_BVALID  = r_bvalid;
  assign S_AXI_INTR_BRESP   = RESP_OKAY;
  assign S_AXI_INTR_ARREADY = r_arready;
  assign S_AXI_INTR_RVALID  = r_rvalid;
  assign S_AXI_INTR_RDATA   = r_rdata;
  assign S_AXI_INTR_RRESP   = RESP_OKAY;
  assign irq                = r_irq;

endmodule

// File: tb/tb_axi_intr_ctrl_multi.sv
// Bench for axi_intr_ctrl_multi: a level-irq and a pulse-irq instance share one
// AXI master and intr_in; read expectations are queued at issue and popped at RVALID.
module tb_axi_intr_ctrl_multi;

  localparam logic [4:0] A_GIE  = 5'h00;
  localparam logic [4:0] A_IER  = 5'h04;
  localparam logic [4:0] A_ISR  = 5'h08;
  localparam logic [4:0] A_IAR  = 5'h0C;
  localparam logic [4:0] A_IPR  = 5'h10;
  localparam logic [4:0] A_SENS = 5'h14;
  localparam logic [4:0] A_POL  = 5'h18;
  localparam logic [4:0] A_ISET = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [3:0]  intr_in;

  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awready_p, wready_p, bvalid_p, arready_p, rvalid_p, irq_p;
  logic [1:0]  bresp_p, rresp_p;
  logic [31:0] rdata_p;

  always #5 clk = ~clk;

  axi_intr_ctrl_multi dut (
    .S_AXI_INTR_ACLK(clk), .S_AXI_INTR_ARESETN(rst_n),
    .S_AXI_INTR_AWADDR(awaddr), .S_AXI_INTR_AWPROT(awprot),
    .S_AXI_INTR_AWVALID(awvalid), .S_AXI_INTR_AWREADY(awready),
    .S_AXI_INTR_WDATA(wdata), .S_AXI_INTR_WSTRB(wstrb),
    .S_AXI_INTR_WVALID(wvalid), .S_AXI_INTR_WREADY(wready),
    .S_AXI_INTR_BRESP(bresp), .S_AXI_INTR_BVALID(bvalid), .S_AXI_INTR_BREADY(bready),
    .S_AXI_INTR_ARADDR(araddr), .S_AXI_INTR_ARPROT(arprot),
    .S_AXI_INTR_ARVALID(arvalid), .S_AXI_INTR_ARREADY(arready),
    .S_AXI_INTR_RDATA(rdata), .S_AXI_INTR_RRESP(rresp),
    .S_AXI_INTR_RVALID(rvalid), .S_AXI_INTR_RREADY(rready),
    .intr_in(intr_in), .irq(irq)
  );

  axi_intr_ctrl_multi #(.C_IRQ_SENSITIVITY(0), .C_IRQ_PULSE_CYCLES(4)) dut_p (
    .S_AXI_INTR_ACLK(clk), .S_AXI_INTR_ARESETN(rst_n),
    .S_AXI_INTR_AWADDR(awaddr), .S_AXI_INTR_AWPROT(awprot),
    .S_AXI_INTR_AWVALID(awvalid), .S_AXI_INTR_AWREADY(awready_p),
    .S_AXI_INTR_WDATA(wdata), .S_AXI_INTR_WSTRB(wstrb),
    .S_AXI_INTR_WVALID(wvalid), .S_AXI_INTR_WREADY(wready_p),
    .S_AXI_INTR_BRESP(bresp_p), .S_AXI_INTR_BVALID(bvalid_p), .S_AXI_INTR_BREADY(bready),
    .S_AXI_INTR_ARADDR(araddr), .S_AXI_INTR_ARPROT(arprot),
    .S_AXI_INTR_ARVALID(arvalid), .S_AXI_INTR_ARREADY(arready_p),
    .S_AXI_INTR_RDATA(rdata_p), .S_AXI_INTR_RRESP(rresp_p),
    .S_AXI_INTR_RVALID(rvalid_p), .S_AXI_INTR_RREADY(rready),
    .intr_in(intr_in), .irq(irq_p)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;
  bit          hist [1:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Returns #1 after the edge that completes the B handshake (write edge + 1).
  task automatic axi_wr(input logic [4:0] addr, input logic [31:0] data,
                        input logic [3:0] strb = 4'hF);
    int cyc;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (!awready) begin
      chk("aw_timeout", 32'(awready), 32'd1);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    last_bresp = bresp;
    if (!bvalid) chk("bvalid_rise", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [4:0] addr, input logic [31:0] exp,
                        input string tag, input bit sel = 1'b0);
    int cyc;
    logic [31:0] e;
    string t;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    if (!arready) begin
      chk({tag, "_ar_timeout"}, 32'(arready), 32'd1);
      arvalid = 1'b0; rready = 1'b0;
      e = exp_q.pop_front(); t = tag_q.pop_front();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!rvalid) chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, sel ? rdata_p : rdata, e);
    last_rresp = sel ? rresp_p : rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; intr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset asserted while a write is mid-handshake.
    @(negedge clk);
    awaddr = A_IER; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {28'h0, awready, wready, arready, bvalid}, 32'h0);
    chk("rst_rvalid_irq", {30'h0, rvalid, irq}, 32'h0);
    chk("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    axi_rd(A_IER, 32'h0, "rst_ier");
    axi_rd(A_SENS, 32'hF, "rst_sens");
    axi_rd(A_POL, 32'hF, "rst_pol");

    // Single edge source: latency and ack.
    axi_wr(A_GIE, 32'h1);
    axi_wr(A_IER, 32'h1);
    @(negedge clk) intr_in = 4'h1;
    repeat (3) @(posedge clk);
    #1 chk("edge_lat3", 32'(irq), 32'd0);
    @(posedge clk);
    #1 chk("edge_lat4", 32'(irq), 32'd1);
    axi_rd(A_IPR, 32'h1, "edge_ipr");
    axi_wr(A_IAR, 32'h1);
    chk("edge_ack_irq", 32'(irq), 32'd0);
    chk("edge_bresp", 32'(last_bresp), 32'd0);
    axi_rd(A_IPR, 32'h0, "edge_ipr_ack");
    intr_in = 4'h0;

    // Multiple sources, partial ack.
    axi_wr(A_IER, 32'h5);
    @(negedge clk) intr_in = 4'hF;
    repeat (2) @(negedge clk);
    intr_in = 4'h0;
    repeat (4) @(posedge clk);
    axi_rd(A_ISR, 32'hF, "multi_isr");
    axi_rd(A_IPR, 32'h5, "multi_ipr");
    axi_wr(A_IAR, 32'h4);
    axi_rd(A_IPR, 32'h1, "multi_ipr_ack4");
    chk("multi_irq_held", 32'(irq), 32'd1);
    axi_wr(A_IAR, 32'h1);
    chk("multi_irq_low", 32'(irq), 32'd0);
    axi_rd(A_ISR, 32'hA, "multi_isr_left");
    axi_wr(A_IAR, 32'hF);

    // Unimplemented bits and byte strobes.
    axi_wr(A_IER, 32'hFFFF_FFFF);
    axi_rd(A_IER, 32'hF, "ier_mask");
    axi_wr(A_IER, 32'h0, 4'h0);
    axi_rd(A_IER, 32'hF, "ier_strb0");

    // GIE gating keeps ISR.
    axi_wr(A_IER, 32'h1);
    axi_wr(A_ISET, 32'h1);
    chk("iset_irq", 32'(irq), 32'd1);
    axi_wr(A_GIE, 32'h0);
    chk("gie_off_irq", 32'(irq), 32'd0);
    axi_rd(A_ISR, 32'h1, "gie_off_isr");
    axi_wr(A_GIE, 32'h1);
    axi_wr(A_IAR, 32'hF);
    axi_wr(A_IER, 32'h0);

    // Edge on source 3 lands on the same edge as an IAR of bit 3.
    @(negedge clk) intr_in = 4'h8;
    axi_wr(A_IAR, 32'h8);
    axi_rd(A_ISR, 32'h8, "collide_isr");
    intr_in = 4'h0;
    axi_wr(A_IAR, 32'h8);
    axi_rd(A_ISR, 32'h0, "iar_isr");
    axi_wr(A_ISET, 32'h8);
    axi_rd(A_ISR, 32'h8, "iset_isr");
    axi_wr(A_IAR, 32'h8);
    axi_wr(A_ISET, 32'h8, 4'h0);
    axi_rd(A_ISR, 32'h0, "iset_strb0");
    axi_rd(A_ISET, 32'h0, "iset_reads0");
    chk("iset_rresp", 32'(last_rresp), 32'd0);
    axi_rd(A_IAR, 32'h0, "iar_reads0");

    // Level sensitivity with an active-low source 1.
    axi_wr(A_SENS, 32'h0);
    axi_wr(A_POL, 32'hD);
    axi_wr(A_IER, 32'h2);
    repeat (4) @(posedge clk);
    axi_rd(A_ISR, 32'h2, "lvl_isr");
    chk("lvl_irq", 32'(irq), 32'd1);
    axi_wr(A_IAR, 32'h2);
    chk("lvl_ack_dip", 32'(irq), 32'd0);
    @(posedge clk);
    #1 chk("lvl_reassert", 32'(irq), 32'd1);
    axi_rd(A_ISR, 32'h2, "lvl_isr_again");
    @(negedge clk) intr_in = 4'h2;
    repeat (4) @(posedge clk);
    axi_wr(A_IAR, 32'h2);
    axi_rd(A_ISR, 32'h0, "lvl_inactive_isr");
    chk("lvl_inactive_irq", 32'(irq), 32'd0);

    // Pulse-mode instance.
    @(negedge clk);
    rst_n = 1'b0; intr_in = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_wr(A_GIE, 32'h1);
    axi_wr(A_IER, 32'h1);
    cnt = 0;
    fork
      axi_wr(A_ISET, 32'h1);
      begin
        repeat (14) begin
          @(posedge clk); #1;
          if (irq_p) cnt++;
        end
      end
    join
    chk("pulse_width", 32'(cnt), 32'd4);
    axi_rd(A_IPR, 32'h1, "pulse_ipr", 1'b1);
    axi_wr(A_IAR, 32'h1);
    axi_wr(A_SENS, 32'h0);

    // Level source 0: the pulse starts at edge 4, IAR on that same edge
    // re-raises the condition so the counter reloads at edge 6.
    @(negedge clk) intr_in = 4'h1;
    fork
      begin
        @(negedge clk);
        axi_wr(A_IAR, 32'h1);
      end
      begin
        for (int k = 1; k <= 16; k++) begin
          @(posedge clk); #1;
          hist[k] = irq_p;
        end
      end
    join
    cnt = 0;
    for (int k = 1; k <= 16; k++) if (hist[k]) cnt++;
    chk("reload_pre", 32'(hist[3]), 32'd0);
    chk("reload_rise", 32'(hist[4]), 32'd1);
    chk("reload_last", {30'h0, hist[9], hist[10]}, 32'h2);
    chk("reload_width", 32'(cnt), 32'd6);
    axi_rd(A_ISET, 32'h0, "pulse_unmapped", 1'b1);
    chk("pulse_rresp", 32'(last_rresp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
